// File: rtl/mem_port_arbiter_if.sv
// Core-side and memory-side signal bundle of the shared memory port arbiter.
// The arbiter takes the slave view; the core/memory environment takes master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              instr_rd_i;
  logic [ADDR_W-1:0] instr_addr_i;
  logic [DATA_W-1:0] instr_data_o;
  logic              instr_ready_o;
  logic              data_rd_i;
  logic              data_wr_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_ready_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;
  logic              err_o;

  modport slave (
    input  instr_rd_i, instr_addr_i,
    input  data_rd_i, data_wr_i, data_addr_i, data_wdata_i,
    input  mem_rdata_i, mem_ack_i,
    output instr_data_o, instr_ready_o,
    output data_rdata_o, data_ready_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output err_o
  );

  modport master (
    output instr_rd_i, instr_addr_i,
    output data_rd_i, data_wr_i, data_addr_i, data_wdata_i,
    output mem_rdata_i, mem_ack_i,
    input  instr_data_o, instr_ready_o,
    input  data_rdata_o, data_ready_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports,
// data first, with buffered results and a per-access ack timeout.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_WORD = 32'h0000_0013
) (
  input logic clk_i,
  input logic rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    DATA_BUSY,
    INSTR_BUSY
  } state_t;

  state_t state, state_n;

  logic          data_done;
  logic          instr_done;
  logic [CW-1:0] cnt;

  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] idata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic data_req;
  logic data_rdy;
  logic instr_rdy;
  logic advance;
  logic tmo_hit;
  logic issue_d;
  logic issue_i;
  logic fin_d;
  logic fin_i;
  logic tmo;

  assign data_req  = bus.data_rd_i | bus.data_wr_i;
  assign data_rdy  = ~data_req | data_done;
  assign instr_rdy = ~bus.instr_rd_i | instr_done;
  assign advance   = instr_rdy & data_rdy;
  assign tmo_hit   = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    issue_d = 1'b0;
    issue_i = 1'b0;
    fin_d   = 1'b0;
    fin_i   = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: begin
        // requests seen in the advance cycle belong to the old round
        if (!advance) begin
          if (data_req && !data_done) begin
            issue_d = 1'b1;
            state_n = DATA_BUSY;
          end else if (bus.instr_rd_i && !instr_done) begin
            issue_i = 1'b1;
            state_n = INSTR_BUSY;
          end
        end
      end
      DATA_BUSY: begin
        if (bus.mem_ack_i) begin
          fin_d   = 1'b1;
          state_n = IDLE;
        end else if (tmo_hit) begin
          fin_d   = 1'b1;
          tmo     = 1'b1;
          state_n = IDLE;
        end
      end
      INSTR_BUSY: begin
        if (bus.mem_ack_i) begin
          fin_i   = 1'b1;
          state_n = IDLE;
        end else if (tmo_hit) begin
          fin_i   = 1'b1;
          tmo     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      data_done  <= 1'b0;
      instr_done <= 1'b0;
      cnt        <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      idata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_n;
      if (advance) begin
        data_done  <= 1'b0;
        instr_done <= 1'b0;
      end
      if (fin_d) data_done <= 1'b1;
      if (fin_i) instr_done <= 1'b1;
      if (state != IDLE) cnt <= cnt + 1'b1;
      if (issue_d) begin
        req_q   <= 1'b1;
        we_q    <= bus.data_wr_i;
        addr_q  <= bus.data_addr_i;
        wdata_q <= bus.data_wdata_i;
        cnt     <= '0;
      end
      if (issue_i) begin
        req_q  <= 1'b1;
        we_q   <= 1'b0;
        addr_q <= bus.instr_addr_i;
        cnt    <= '0;
      end
      if (fin_d || fin_i) req_q <= 1'b0;
      if (fin_d && !we_q) rdata_q <= tmo ? ERR_WORD : bus.mem_rdata_i;
      if (fin_i) idata_q <= tmo ? ERR_WORD : bus.mem_rdata_i;
      if (tmo) err_q <= 1'b1;
    end
  end

  assign bus.instr_data_o  = idata_q;
  assign bus.instr_ready_o = instr_rdy;
  assign bus.data_rdata_o  = rdata_q;
  assign bus.data_ready_o  = data_rdy;
  assign bus.mem_req_o     = req_q;
  assign bus.mem_we_o      = we_q;
  assign bus.mem_addr_o    = addr_q;
  assign bus.mem_wdata_o   = wdata_q;
  assign bus.err_o         = err_q;

endmodule
